// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: datapath width,
// loader state encoding and the word-index to byte-address helper.
package imem_loader_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LOAD = 3'd1,
        LDR_CSUM = 3'd2,
        LDR_DONE = 3'd3,
        LDR_ERR  = 3'd4
    } ldr_state_e;

    function automatic logic [CPU_WIDTH-1:0] ldr_word_addr(
        input logic [CPU_WIDTH-1:0] base,
        input logic [CPU_WIDTH-1:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into inst_mem and holds the core in reset
// until the image is loaded. Define IMEM_LOADER_CSUM_EN for a trailing checksum beat.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                   DEPTH     = 256,
    parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                   AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_start,
    input  logic                 s_valid,
    input  logic [CPU_WIDTH-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 imem_we,
    output logic [CPU_WIDTH-1:0] imem_waddr,
    output logic [CPU_WIDTH-1:0] imem_wdata,
    output logic                 core_rstn,
    output logic                 load_done,
    output logic                 load_err,
    output logic [AW:0]          word_count
);

    localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

    ldr_state_e           r_state;
    ldr_state_e           w_next_state;
    logic [AW:0]          r_word_count;
    logic                 r_we;
    logic [CPU_WIDTH-1:0] r_waddr;
    logic [CPU_WIDTH-1:0] r_wdata;
    logic                 r_core_rstn;

    logic w_accept;
    logic w_data_beat;
    logic w_start;
    logic w_at_last_slot;

    assign s_ready        = (r_state == LDR_LOAD) || (r_state == LDR_CSUM);
    assign w_accept       = s_valid && s_ready;
    assign w_data_beat    = w_accept && (r_state == LDR_LOAD);
    assign w_start        = load_start &&
                            ((r_state == LDR_IDLE) || (r_state == LDR_DONE) || (r_state == LDR_ERR));
    assign w_at_last_slot = (r_word_count == LAST_SLOT);

`ifdef IMEM_LOADER_CSUM_EN
    logic [CPU_WIDTH-1:0] r_sum;
    logic [CPU_WIDTH-1:0] w_sum_next;

    assign w_sum_next = r_sum + s_data;

    // Running sum only matters between load_start and the checksum beat.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_sum <= '0;
        end else if (w_data_beat) begin
            r_sum <= w_sum_next;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LDR_IDLE: begin
                if (load_start) w_next_state = LDR_LOAD;
            end
            LDR_LOAD: begin
                if (w_accept) begin
                    if (s_last) begin
`ifdef IMEM_LOADER_CSUM_EN
                        w_next_state = LDR_CSUM;
`else
                        w_next_state = LDR_DONE;
`endif
                    end else if (w_at_last_slot) begin
                        w_next_state = LDR_ERR;
                    end
                end
            end
            LDR_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
                if (w_accept) begin
                    w_next_state = (w_sum_next == '0) ? LDR_DONE : LDR_ERR;
                end
`else
                w_next_state = LDR_IDLE;
`endif
            end
            LDR_DONE: begin
                if (load_start) w_next_state = LDR_LOAD;
            end
            LDR_ERR: begin
                if (load_start) w_next_state = LDR_LOAD;
            end
            default: w_next_state = LDR_IDLE;
        endcase
    end

    // Stage boundary: accepted beat becomes a registered memory write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= LDR_IDLE;
            r_word_count <= '0;
            r_we         <= 1'b0;
            r_waddr      <= BASE_ADDR;
            r_wdata      <= '0;
            r_core_rstn  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_core_rstn <= (w_next_state == LDR_DONE);
            r_we        <= w_data_beat;
            if (w_start) begin
                r_word_count <= '0;
            end else if (w_data_beat) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_data_beat) begin
                r_waddr <= ldr_word_addr(BASE_ADDR, CPU_WIDTH'(r_word_count));
                r_wdata <= s_data;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign core_rstn  = r_core_rstn;
    assign load_done  = (r_state == LDR_DONE);
    assign load_err   = (r_state == LDR_ERR);
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (DEPTH=4, non-zero base); covers the
// checksum scenario when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0100;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_LOAD = 1, S_CSUM = 2, S_DONE = 3, S_ERR = 4;

    logic        clk = 1'b0;
    logic        rstn, load_start, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, imem_we, core_rstn, load_done, load_err;
    logic [31:0] imem_waddr, imem_wdata;
    logic [AW:0] word_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_state = S_IDLE;
    int          m_cnt = 0;
    logic [31:0] m_sum = '0;
    logic [63:0] exp_q[$];

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rstn(core_rstn), .load_done(load_done), .load_err(load_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Write monitor: every write must match the oldest expected beat.
    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            logic [63:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_waddr, imem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_waddr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step(input logic rn, input logic st, input logic v,
                        input logic [31:0] d, input logic l);
        logic rdy_exp;
        @(negedge clk);
        rstn = rn; load_start = st; s_valid = v; s_data = d; s_last = l;
        rdy_exp = (m_state == S_LOAD) || (m_state == S_CSUM);
        if (rn) begin
            n_cmp++;
            if (s_ready !== rdy_exp) begin
                n_err++;
                $display("FAIL s_ready: got %b, required %b", s_ready, rdy_exp);
            end
        end
        if (rn && v && m_state == S_LOAD) exp_q.push_back({BASE + 32'(m_cnt * 4), d});
        @(posedge clk);
        if (!rn) begin
            m_state = S_IDLE; m_cnt = 0;
        end else begin
            case (m_state)
                S_LOAD: if (v) begin
                    m_sum = m_sum + d;
                    if (l) m_state = CSUM_EN ? S_CSUM : S_DONE;
                    else if (m_cnt == DEPTH - 1) m_state = S_ERR;
                    m_cnt++;
                end
                S_CSUM: if (v) m_state = ((m_sum + d) == 32'h0) ? S_DONE : S_ERR;
                default: if (st) begin
                    m_state = S_LOAD; m_cnt = 0; m_sum = '0;
                end
            endcase
        end
        #1;
        n_cmp++;
        if ({word_count, load_done, load_err, core_rstn} !==
            {(AW+1)'(m_cnt), m_state == S_DONE, m_state == S_ERR, m_state == S_DONE}) begin
            n_err++;
            $display("FAIL status: got cnt=%0d done=%b err=%b core_rstn=%b, required cnt=%0d state=%0d",
                     word_count, load_done, load_err, core_rstn, m_cnt, m_state);
        end
    endtask

    task automatic idle_cycle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic close_load();
        if (CSUM_EN) step(1'b1, 1'b0, 1'b1, (~m_sum) + 32'h1, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if ({imem_we, imem_waddr, imem_wdata, core_rstn, load_done, load_err, word_count, s_ready} !==
            {1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got we=%b addr=%h data=%h crst=%b done=%b err=%b cnt=%0d rdy=%b, required all idle, addr=%h",
                     imem_we, imem_waddr, imem_wdata, core_rstn, load_done, load_err, word_count, s_ready, BASE);
        end
        idle_cycle();
    endtask

    task automatic test_basic();
        logic [31:0] w[3] = '{32'h0050_0093, 32'h0010_8113, 32'h0020_81B3};
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, w[i], i == 2);
            n_cmp++;
            if ({imem_we, imem_waddr} !== {1'b1, BASE + 32'(i * 4)}) begin
                n_err++;
                $display("FAIL basic_wr%0d: got we=%b addr=%h, required we=1 addr=%h",
                         i, imem_we, imem_waddr, BASE + 32'(i * 4));
            end
        end
        close_load();
        n_cmp++;
        if ({load_done, core_rstn, word_count} !== {1'b1, 1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL basic_done: got done=%b crst=%b cnt=%0d, required 1 1 3", load_done, core_rstn, word_count);
        end
    endtask

    task automatic test_gaps();
        int i;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (i = 0; i < 60 && m_state == S_LOAD; i++) begin
            logic v;
            v = (i % 2 == 0) && ($urandom_range(0, 3) != 0);
            step(1'b1, (i == 5), v, $urandom, v && (m_cnt == 2));
        end
        n_cmp++;
        if (m_state == S_LOAD) begin
            n_err++;
            $display("FAIL gaps_timeout: got %0d beats in 60 cycles, required 3", m_cnt);
        end
        close_load();
        n_cmp++;
        if ({load_done, word_count} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL gaps_done: got done=%b cnt=%0d, required 1 3", load_done, word_count);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 32'hA000_0000 + i, 1'b0);
        n_cmp++;
        if ({load_err, core_rstn, word_count, s_ready, imem_we} !== {1'b1, 1'b0, 3'd4, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL overflow: got err=%b crst=%b cnt=%0d rdy=%b we=%b, required 1 0 4 0 0",
                     load_err, core_rstn, word_count, s_ready, imem_we);
        end
    endtask

    task automatic test_boundary();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'hB000_0000 + i, i == 3);
        close_load();
        n_cmp++;
        if ({load_done, load_err, word_count} !== {1'b1, 1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL boundary: got done=%b err=%b cnt=%0d, required 1 0 4", load_done, load_err, word_count);
        end
    endtask

    task automatic test_reload();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if ({core_rstn, load_done, word_count} !== {1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL reload_start: got crst=%b done=%b cnt=%0d, required 0 0 0", core_rstn, load_done, word_count);
        end
        step(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b1);
        n_cmp++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, BASE, 32'h13}) begin
            n_err++;
            $display("FAIL reload_wr: got we=%b addr=%h data=%h, required 1 %h 00000013", imem_we, imem_waddr, imem_wdata, BASE);
        end
        close_load();
        n_cmp++;
        if ({load_done, core_rstn, word_count} !== {1'b1, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL reload_done: got done=%b crst=%b cnt=%0d, required 1 1 1", load_done, core_rstn, word_count);
        end
    endtask

    task automatic test_midreset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hC000_0000, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hC000_0001, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hC000_0002, 1'b0);
        n_cmp++;
        if ({imem_we, s_ready, word_count, load_done, core_rstn} !== {1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset: got we=%b rdy=%b cnt=%0d done=%b crst=%b, required 0 0 0 0 0",
                     imem_we, s_ready, word_count, load_done, core_rstn);
        end
        step(1'b1, 1'b0, 1'b1, 32'hC000_0003, 1'b0);
        n_cmp++;
        if ({imem_we, s_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_idle: got we=%b rdy=%b, required 0 0", imem_we, s_ready);
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        n_cmp++;
        if ({load_done, load_err, word_count, imem_we} !== {1'b1, 1'b0, 3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL csum_good: got done=%b err=%b cnt=%0d we=%b, required 1 0 2 0", load_done, load_err, word_count, imem_we);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        n_cmp++;
        if ({load_done, load_err, core_rstn, imem_we} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL csum_bad: got done=%b err=%b crst=%b we=%b, required 0 1 0 0", load_done, load_err, core_rstn, imem_we);
        end
    endtask
`endif

    initial begin
        rstn = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_boundary();
        test_reload();
        test_midreset();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        idle_cycle();
        idle_cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_writes: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
